uart_rx: RTL

- 8N1 UART receiver: the receive-side counterpart of the existing UART transmitter.
- Deserialises the rx pin into bytes and holds each byte in a one-entry holding register with a valid flag.
- Raises sticky framing and overrun error flags.
- The load/store unit reads the byte through a memory-mapped load; that read pulses rd_en_i. Runs on the divided core clock (clk_o domain).

---
 rtl/uart_rx_if.sv | 20 ++
 rtl/uart_rx.sv | 119 +++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Register-read side of the UART receiver: one-cycle read strobe plus the held byte and status.
// The slave modport is the receiver; the master modport is the load/store unit.
interface uart_rx_if;
    logic       rd_en_i;
    logic [7:0] data_o;
    logic       byte_valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    modport master (
        output rd_en_i,
        input  data_o, byte_valid_o, frame_err_o, overrun_o, busy_o
    );

    modport slave (
        input  rd_en_i,
        output data_o, byte_valid_o, frame_err_o, overrun_o, busy_o
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry holding register; byte_valid rises ~2+HALF+9*CLKS_PER_BIT clk after the start edge.
// No backpressure on the line: a byte that completes while the holder is full and unread is dropped and flagged as overrun.
module uart_rx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_i,
    uart_rx_if.slave   bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          rx_meta;
    logic          rx_s;
    logic [7:0]    data_q;
    logic          valid_q;
    logic          frame_err_q;
    logic          overrun_q;
    logic          busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta <= rx_i;
            rx_s    <= rx_meta;

            // Read clears first; any flag set later in this block wins over the clear.
            if (bus.rd_en_i) begin
                valid_q     <= 1'b0;
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            idx   <= '0;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (idx == 3'd7) state <= STOP;
                        else             idx   <= idx + 3'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    // Leave at mid-stop so an immediately following start bit is not missed.
                    if (cnt == BIT_LAST) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (rx_s) begin
                            if (!valid_q || bus.rd_en_i) begin
                                data_q  <= shift;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_o       = data_q;
    assign bus.byte_valid_o = valid_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.overrun_o    = overrun_q;
    assign bus.busy_o       = busy_q;
endmodule
